// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: channel FSM state encoding
// and the smallest stable-sample count the design can honour.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_CHK_H = 2'd1,
        S_HIGH  = 2'd2,
        S_CHK_L = 2'd3
    } state_t;

    localparam int MIN_DB_CYCLES = 2;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: two-flop synchronizer, four-state acceptance FSM
// with a stability counter, and registered level/rise/fall outputs.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES = 120000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
);

    if (DB_CYCLES < MIN_DB_CYCLES) begin : g_badDbCycles
        $error("debounce_channel: DB_CYCLES must be at least 2");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync0;
    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             levelNext;
    logic             riseNext;
    logic             fallNext;

    // Every output is a flop, so nothing combinational reaches btn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync0 <= 1'b0;
            state <= S_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync0 <= sync1;
            state <= stateNext;
            cnt   <= cntNext;
            level <= levelNext;
            rise  <= riseNext;
            fall  <= fallNext;
        end
    end

    // Any sample matching the old level aborts a check and clears the count.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        levelNext = level;
        riseNext  = 1'b0;
        fallNext  = 1'b0;
        case (state)
            S_LOW: begin
                if (sync0) begin
                    stateNext = S_CHK_H;
                    cntNext   = CNT_W'(1);
                end
            end
            S_CHK_H: begin
                if (!sync0) begin
                    stateNext = S_LOW;
                    cntNext   = '0;
                end else if (cnt == CNT_MAX) begin
                    stateNext = S_HIGH;
                    levelNext = 1'b1;
                    riseNext  = 1'b1;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!sync0) begin
                    stateNext = S_CHK_L;
                    cntNext   = CNT_W'(1);
                end
            end
            S_CHK_L: begin
                if (sync0) begin
                    stateNext = S_HIGH;
                    cntNext   = '0;
                end else if (cnt == CNT_MAX) begin
                    stateNext = S_LOW;
                    levelNext = 1'b0;
                    fallNext  = 1'b1;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = S_LOW;
                cntNext   = '0;
                levelNext = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/debounce_inputs.sv
// Input conditioning for the board's three logic inputs: N_CH independent
// debounced channels producing stable levels plus rise/fall pulses.
module debounce_inputs
    import debounce_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int DB_CYCLES = 120000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    if (DB_CYCLES < MIN_DB_CYCLES) begin : g_badDbCycles
        $error("debounce_inputs: DB_CYCLES must be at least 2");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_channel
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_channel (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_in[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_inputs.sv
// Self-checking bench for debounce_inputs: directed scenarios plus random
// pin activity, all compared against a per-channel stability-streak model.
module tb_debounce_inputs;

    localparam int N_CH = 3;
    localparam int DB   = 4;

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    int checks   = 0;
    int failures = 0;

    logic            monEn = 1'b0;
    logic [N_CH-1:0] riseAcc;
    logic [N_CH-1:0] fallAcc;

    logic [N_CH-1:0] mPipe1;
    logic [N_CH-1:0] mPipe0;
    logic [N_CH-1:0] mLevel;
    logic [N_CH-1:0] mRise;
    logic [N_CH-1:0] mFall;
    int              mStreak [N_CH];

    debounce_inputs #(
        .N_CH      (N_CH),
        .DB_CYCLES (DB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (btn_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // The pin reaches the acceptance logic two edges late; a level flips once
    // DB consecutive delayed samples have disagreed with it.
    always @(posedge clk) begin : refModel
        logic [N_CH-1:0] nLevel;
        logic [N_CH-1:0] nRise;
        logic [N_CH-1:0] nFall;
        int              nStreak [N_CH];
        nLevel = mLevel;
        nRise  = '0;
        nFall  = '0;
        for (int c = 0; c < N_CH; c++) begin
            nStreak[c] = mStreak[c];
            if (!rst_n) begin
                nLevel[c]  = 1'b0;
                nStreak[c] = 0;
            end else if (mPipe0[c] != mLevel[c]) begin
                nStreak[c] = mStreak[c] + 1;
                if (nStreak[c] == DB) begin
                    nLevel[c]  = mPipe0[c];
                    nRise[c]   = mPipe0[c];
                    nFall[c]   = ~mPipe0[c];
                    nStreak[c] = 0;
                end
            end else begin
                nStreak[c] = 0;
            end
        end
        mPipe1  <= rst_n ? btn_in : '0;
        mPipe0  <= rst_n ? mPipe1 : '0;
        mLevel  <= nLevel;
        mRise   <= nRise;
        mFall   <= nFall;
        mStreak <= nStreak;
    end

    always @(negedge clk) begin
        if (monEn) begin
            checkOutput("model_level", 32'(level), 32'(mLevel));
            checkOutput("model_rise", 32'(rise), 32'(mRise));
            checkOutput("model_fall", 32'(fall), 32'(mFall));
            checkOutput("rise_fall_exclusive", 32'(rise & fall), 32'd0);
        end
    end

    task automatic applyStimulus(input logic [N_CH-1:0] pins, input logic rstVal);
        btn_in = pins;
        rst_n  = rstVal;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            riseAcc |= rise;
            fallAcc |= fall;
        end
    endtask

    task automatic measureLatency(input string tag, input logic [N_CH-1:0] target, input int expEdges);
        int k;
        k = 0;
        while (k <= 40) begin
            @(negedge clk);
            k++;
            riseAcc |= rise;
            fallAcc |= fall;
            if (level == target) break;
        end
        checkOutput(tag, 32'(k), 32'(expEdges));
    endtask

    initial begin
        riseAcc = '0;
        fallAcc = '0;
        applyStimulus(3'b111, 1'b0);
        @(posedge clk);
        monEn = 1'b1;

        // Reset with inputs held high
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_level", 32'(level), 32'd0);
            checkOutput("reset_rise", 32'(rise), 32'd0);
        end
        applyStimulus(3'b111, 1'b1);
        measureLatency("reset_release_latency", 3'b111, 6);
        checkOutput("reset_release_rise", 32'(rise), 32'b111);
        @(negedge clk);
        checkOutput("reset_release_rise_once", 32'(rise), 32'd0);

        applyStimulus(3'b000, 1'b1);
        waitCycles(10);

        // Clean press and release on A
        riseAcc = '0;
        fallAcc = '0;
        applyStimulus(3'b001, 1'b1);
        measureLatency("press_a_latency", 3'b001, 6);
        checkOutput("press_a_rise", 32'(rise), 32'b001);
        waitCycles(6);
        checkOutput("press_a_rise_only_a", 32'(riseAcc), 32'b001);
        applyStimulus(3'b000, 1'b1);
        measureLatency("release_a_latency", 3'b000, 6);
        checkOutput("release_a_fall", 32'(fall), 32'b001);
        waitCycles(4);
        checkOutput("press_a_fall_only_a", 32'(fallAcc), 32'b001);

        // Glitch shorter than the acceptance window on B
        riseAcc = '0;
        fallAcc = '0;
        applyStimulus(3'b010, 1'b1);
        waitCycles(3);
        applyStimulus(3'b000, 1'b1);
        waitCycles(8);
        checkOutput("glitch3_level", 32'(level), 32'd0);
        checkOutput("glitch3_pulses", 32'(riseAcc | fallAcc), 32'd0);

        // Pulse exactly DB wide on B is accepted
        applyStimulus(3'b010, 1'b1);
        waitCycles(4);
        applyStimulus(3'b000, 1'b1);
        measureLatency("glitch4_rise_latency", 3'b010, 2);
        checkOutput("glitch4_rise", 32'(rise), 32'b010);
        measureLatency("glitch4_fall_latency", 3'b000, 4);
        checkOutput("glitch4_fall", 32'(fall), 32'b010);

        // Bounce on C, then a stable high
        waitCycles(4);
        riseAcc = '0;
        fallAcc = '0;
        for (int t = 0; t < 20; t++) begin
            applyStimulus(((t / 2) % 2 == 0) ? 3'b100 : 3'b000, 1'b1);
            waitCycles(1);
        end
        checkOutput("bounce_no_pulse", 32'(riseAcc | fallAcc), 32'd0);
        applyStimulus(3'b100, 1'b1);
        measureLatency("bounce_settle_latency", 3'b100, 6);
        checkOutput("bounce_settle_rise", 32'(rise), 32'b100);

        applyStimulus(3'b000, 1'b1);
        waitCycles(10);

        // Simultaneous change on A and C
        riseAcc = '0;
        fallAcc = '0;
        applyStimulus(3'b101, 1'b1);
        measureLatency("simul_latency", 3'b101, 6);
        checkOutput("simul_rise", 32'(rise), 32'b101);
        waitCycles(3);
        checkOutput("simul_no_fall", 32'(fallAcc), 32'd0);

        applyStimulus(3'b000, 1'b1);
        waitCycles(10);

        // Reset in the middle of a check on A
        riseAcc = '0;
        fallAcc = '0;
        applyStimulus(3'b001, 1'b1);
        waitCycles(3);
        applyStimulus(3'b001, 1'b0);
        waitCycles(2);
        checkOutput("midreset_no_rise", 32'(riseAcc), 32'd0);
        applyStimulus(3'b001, 1'b1);
        measureLatency("midreset_latency", 3'b001, 6);
        checkOutput("midreset_rise", 32'(rise), 32'b001);

        // Random pin activity with occasional resets
        for (int s = 0; s < 60; s++) begin
            applyStimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 15) != 0));
            waitCycles($urandom_range(1, 8));
        end
        applyStimulus(3'b000, 1'b1);
        waitCycles(10);
        checkOutput("final_level", 32'(level), 32'd0);

        monEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
